// File: rtl/led_display_scanner.sv
// Round-robin scanner that reads the 8-entry LED RAM and drives a multiplexed,
// active-low 8-digit 7-segment display. Optional macro HEX_DECODE_EN selects hex glyph decoding.
module led_display_scanner #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic [2:0] read_address,
   input  logic [7:0] Read_Data,
   output logic [7:0] seg_n,
   output logic [7:0] an_n,
   output logic       frame_done
);

   localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, BLANK, SHOW} state_t;

   state_t        state_q, state_d;
   logic [2:0]    digit_q, digit_d;
   logic [CW-1:0] counter_q, counter_d;
   logic [7:0]    seg_n_q, seg_n_d;
   logic [7:0]    an_n_q, an_n_d;
   logic          frame_done_q, frame_done_d;
   logic [7:0]    digit_sel;
   logic [7:0]    seg_latch;

`ifdef HEX_DECODE_EN
   logic [6:0] glyph;

   always_comb begin
      glyph = 7'h00;
      case (Read_Data[3:0])
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         default: glyph = 7'h71;
      endcase
   end

   assign seg_latch = ~{Read_Data[7], glyph};
`else
   assign seg_latch = ~Read_Data;
`endif

   // Anode select is derived from the next digit so an_n lines up with the SHOW state.
   for (genvar gi = 0; gi < 8; gi++) begin : g_anode
      assign digit_sel[gi] = (digit_d == 3'(gi));
   end

   always_comb begin
      state_d      = state_q;
      digit_d      = digit_q;
      counter_d    = counter_q;
      seg_n_d      = seg_n_q;
      frame_done_d = 1'b0;

      if (!enable) begin
         state_d   = IDLE;
         digit_d   = 3'd0;
         counter_d = '0;
         seg_n_d   = 8'hFF;
      end else begin
         case (state_q)
            IDLE: begin
               state_d   = FETCH;
               digit_d   = 3'd0;
               counter_d = '0;
               seg_n_d   = 8'hFF;
            end
            FETCH: begin
               seg_n_d   = seg_latch;
               counter_d = '0;
               state_d   = (BLANK_CYCLES > 0) ? BLANK : SHOW;
            end
            BLANK: begin
               if (counter_q == BLANK_LAST) begin
                  counter_d = '0;
                  state_d   = SHOW;
               end else begin
                  counter_d = counter_q + CW'(1);
               end
            end
            SHOW: begin
               if (counter_q == SHOW_LAST) begin
                  counter_d    = '0;
                  digit_d      = digit_q + 3'd1;
                  frame_done_d = (digit_q == LAST_DIGIT);
                  state_d      = FETCH;
               end else begin
                  counter_d = counter_q + CW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      an_n_d = (state_d == SHOW) ? ~digit_sel : 8'hFF;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         digit_q      <= 3'd0;
         counter_q    <= '0;
         seg_n_q      <= 8'hFF;
         an_n_q       <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         digit_q      <= digit_d;
         counter_q    <= counter_d;
         seg_n_q      <= seg_n_d;
         an_n_q       <= an_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign read_address = digit_q;
   assign seg_n        = seg_n_q;
   assign an_n         = an_n_q;
   assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_led_display_scanner.sv
// Bench for led_display_scanner: timeline-based reference model checked every cycle,
// plus directed literal expectations for the scan sequence.
module tb_led_display_scanner;

   localparam int R = 4;
   localparam int B = 2;
   localparam int P = 1 + B + R;
   localparam int F = 8 * P;

`ifdef HEX_DECODE_EN
   localparam logic [7:0] LIT_06 = 8'h82;
   localparam logic [7:0] LIT_3F = 8'h8E;
   localparam logic [7:0] LIT_85 = 8'h12;
   localparam logic [7:0] LIT_0A = 8'h88;
`else
   localparam logic [7:0] LIT_06 = 8'hF9;
   localparam logic [7:0] LIT_3F = 8'hC0;
   localparam logic [7:0] LIT_85 = 8'h7A;
   localparam logic [7:0] LIT_0A = 8'hF5;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] read_address;
   logic [7:0] read_data;
   logic [7:0] seg_n;
   logic [7:0] an_n;
   logic       frame_done;
   logic [7:0] mem [8];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign read_data = mem[read_address];

   led_display_scanner #(
      .NUM_DIGITS  (8),
      .REFRESH_DIV (R),
      .BLANK_CYCLES(B)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .read_address(read_address),
      .Read_Data   (read_data),
      .seg_n       (seg_n),
      .an_n        (an_n),
      .frame_done  (frame_done)
   );

   function automatic logic [7:0] model_seg(input logic [7:0] d);
`ifdef HEX_DECODE_EN
      logic [6:0] g;
      logic [6:0] tbl [16];
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      g = tbl[d[3:0]];
      return ~{d[7], g};
`else
      return ~d;
`endif
   endfunction

   // Model: t counts cycles since the first FETCH of the current run.
   bit         active = 0;
   bit         model_valid = 0;
   int         t = 0;
   logic [7:0] exp_seg = 8'hFF;
   logic [7:0] exp_an = 8'hFF;
   logic [2:0] exp_addr = 3'd0;
   logic       exp_fd = 1'b0;

   always @(posedge clk) begin
      if (reset || !enable) begin
         active   = 0;
         t        = 0;
         exp_seg  = 8'hFF;
         exp_an   = 8'hFF;
         exp_addr = 3'd0;
         exp_fd   = 1'b0;
      end else begin
         if (!active) begin
            active = 1;
            t      = 0;
         end else begin
            if (t % P == 0) exp_seg = model_seg(mem[(t / P) % 8]);
            t++;
         end
         exp_fd   = (t > 0) && (t % F == 0);
         exp_addr = 3'((t / P) % 8);
         exp_an   = (t % P > B) ? ~(8'd1 << ((t / P) % 8)) : 8'hFF;
      end
      model_valid = 1;
   end

   always @(negedge clk) begin
      if (model_valid) begin
         checks++;
         if (seg_n !== exp_seg || an_n !== exp_an || read_address !== exp_addr ||
             frame_done !== exp_fd) begin
            errors++;
            $display("FAIL model t=%0d: got seg=%h an=%h addr=%0d fd=%b expected seg=%h an=%h addr=%0d fd=%b",
                     t, seg_n, an_n, read_address, frame_done, exp_seg, exp_an, exp_addr, exp_fd);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end else begin
         $display("check %s: %h", name, act);
      end
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      for (int k = 0; k < 8; k++) mem[k] = 8'(k + 1);
      mem[0] = 8'h06;
      mem[2] = 8'h3F;

      step(2);
      chk("reset_an", an_n, 8'hFF);
      chk("reset_seg", seg_n, 8'hFF);
      chk("reset_fd", {7'd0, frame_done}, 8'h00);
      chk("reset_addr", {5'd0, read_address}, 8'h00);
      reset = 1'b0;

      step(1);   // cycle 0: FETCH digit 0
      chk("fetch0_an", an_n, 8'hFF);
      chk("fetch0_seg", seg_n, 8'hFF);
      step(1);   // cycle 1: BLANK
      chk("blank0_an", an_n, 8'hFF);
      chk("blank0_seg", seg_n, LIT_06);
      step(2);   // cycle 3: first SHOW
      chk("show0_an", an_n, 8'hFE);
      chk("show0_seg", seg_n, LIT_06);
      step(3);   // cycle 6: last SHOW
      chk("show0_last_an", an_n, 8'hFE);
      step(1);   // cycle 7: FETCH digit 1
      chk("fetch1_an", an_n, 8'hFF);
      chk("fetch1_addr", {5'd0, read_address}, 8'h01);

      step(10);  // cycle 17: digit 2 SHOW
      chk("show2_an", an_n, 8'hFB);
      chk("show2_seg", seg_n, LIT_3F);
      mem[2] = 8'h06;
      step(3);   // cycle 20: still digit 2
      chk("show2_hold_seg", seg_n, LIT_3F);

      step(36);  // cycle 56: frame_done
      chk("frame_done_hi", {7'd0, frame_done}, 8'h01);
      chk("wrap_addr", {5'd0, read_address}, 8'h00);
      step(1);
      chk("frame_done_lo", {7'd0, frame_done}, 8'h00);

      step(16);  // cycle 73: digit 2 of next frame
      chk("show2_new_seg", seg_n, LIT_06);
      chk("show2_new_an", an_n, 8'hFB);

      step(22);  // cycle 95: second SHOW cycle of digit 5
      chk("show5_an", an_n, 8'hDF);
      enable = 1'b0;
      step(1);
      chk("dis_an", an_n, 8'hFF);
      chk("dis_seg", seg_n, 8'hFF);
      chk("dis_fd", {7'd0, frame_done}, 8'h00);
      chk("dis_addr", {5'd0, read_address}, 8'h00);

      mem[3] = 8'h85;
      step(3);
      enable = 1'b1;
      step(1);   // restart: FETCH digit 0
      chk("reen_addr", {5'd0, read_address}, 8'h00);
      chk("reen_an", an_n, 8'hFF);
      step(24);  // digit 3 first SHOW cycle
      chk("show3_an", an_n, 8'hF7);
      chk("show3_seg85", seg_n, LIT_85);
      mem[3] = 8'h0A;
      step(F);
      chk("show3_seg0a", seg_n, LIT_0A);

      step(5);
      reset = 1'b1;
      step(1);
      chk("midreset_an", an_n, 8'hFF);
      chk("midreset_seg", seg_n, 8'hFF);
      reset = 1'b0;
      step(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
